// File: rtl/approx_mult_pkg.sv
// rtl/approx_mult_pkg.sv - shared constants and reference product for the approximate multiplier
package approx_mult_pkg;

  localparam int ADDER_RIPPLE = 0;
  localparam int ADDER_CLA    = 1;
  localparam int CNT_W        = 32;
  localparam int MAX_W        = 32;

  localparam logic [2*MAX_W-1:0] REF_ONE = 1;

  // Bit-level reference: keep terms at or above column k, fold the rest into bit k-1.
  function automatic logic [2*MAX_W-1:0] approx_product(input logic [MAX_W-1:0] a,
                                                        input logic [MAX_W-1:0] b,
                                                        input int k,
                                                        input logic approx);
    logic [2*MAX_W-1:0] acc;
    logic               dropped;
    acc     = '0;
    dropped = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      for (int j = 0; j < MAX_W; j++) begin
        if (a[i] && b[j]) begin
          if (!approx || (i + j) >= k) acc = acc + (REF_ONE << (i + j));
          else dropped = 1'b1;
        end
      end
    end
    if (approx && dropped) acc[k-1] = 1'b1;
    return acc;
  endfunction

endpackage

// File: rtl/approx_pp_array.sv
// rtl/approx_pp_array.sv - partial-product array with column truncation, compensation and final adder
module approx_pp_array
  import approx_mult_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int TRUNC_COLS = 8,
  parameter int ADDER_SEL  = ADDER_RIPPLE
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               approx,
  output logic [2*WIDTH-1:0] p
);

  localparam int            PW       = 2 * WIDTH;
  localparam logic [PW-1:0] ONE      = 1;
  localparam logic [PW-1:0] LOW_MASK = (ONE << TRUNC_COLS) - ONE;
  localparam logic [PW-1:0] COMP_BIT = ONE << (TRUNC_COLS - 1);

  logic [PW-1:0] row_sum;
  logic [PW-1:0] last_row;
  logic [PW-1:0] sum;
  logic          comp;

  // All rows but the last are accumulated here; the last row goes through the selected final adder.
  always_comb begin
    logic [PW-1:0] row;
    logic [PW-1:0] kept_mask;
    row       = '0;
    kept_mask = approx ? ~LOW_MASK : '1;
    row_sum   = '0;
    last_row  = '0;
    comp      = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      row  = a[i] ? (PW'(b) << i) : '0;
      comp = comp | (approx & (|(row & LOW_MASK)));
      if (i == WIDTH - 1) last_row = row & kept_mask;
      else                row_sum  = row_sum + (row & kept_mask);
    end
  end

  generate
    if (ADDER_SEL == ADDER_CLA) begin : g_cla
      // 4-bit lookahead groups; group carries ripple between groups.
      always_comb begin
        logic [PW-1:0] g;
        logic [PW-1:0] pr;
        logic [PW-1:0] c;
        logic          cl;
        logic          pp;
        g  = row_sum & last_row;
        pr = row_sum ^ last_row;
        c  = '0;
        cl = 1'b0;
        pp = 1'b1;
        for (int blk = 0; blk < PW; blk += 4) begin
          for (int k = 0; k < 4; k++) begin
            if (blk + k + 1 < PW) begin
              cl = 1'b0;
              pp = 1'b1;
              for (int m = k; m >= 0; m--) begin
                cl = cl | (g[blk+m] & pp);
                pp = pp & pr[blk+m];
              end
              c[blk+k+1] = cl | (pp & c[blk]);
            end
          end
        end
        sum = pr ^ c;
      end
    end else begin : g_ripple
      always_comb begin
        logic c;
        c   = 1'b0;
        sum = '0;
        for (int i = 0; i < PW; i++) begin
          sum[i] = row_sum[i] ^ last_row[i] ^ c;
          c      = (row_sum[i] & last_row[i]) | ((row_sum[i] ^ last_row[i]) & c);
        end
      end
    end
  endgenerate

  assign p = sum | (comp ? COMP_BIT : '0);

endmodule

// File: rtl/approx_mult_pipe.sv
// rtl/approx_mult_pipe.sv - two-stage valid/ready approximate multiplier with operand isolation
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int TRUNC_COLS = 8,
  parameter int ADDER_SEL  = ADDER_RIPPLE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Z,
  output logic               zero_skip,
  input  logic               stat_clr,
  output logic [CNT_W-1:0]   gated_cycles
);

  logic               s1_valid;
  logic               s1_approx;
  logic               s1_zero;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  logic [2*WIDTH-1:0] prod;
  logic [CNT_W-1:0]   gated_cnt;
  logic               s1_en;
  logic               s2_en;
  logic               s1_load;
  logic               s2_load;
  logic               in_zero;

  assign s2_en        = !out_valid || out_ready;
  assign s1_en        = !s1_valid || s2_en;
  assign in_ready     = s1_en;
  assign s1_load      = in_valid && s1_en;
  assign s2_load      = s1_valid && s2_en;
  assign in_zero      = (A == '0) || (B == '0);
  assign gated_cycles = gated_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_valid <= 1'b0;
    else if (s1_en) s1_valid <= in_valid;
  end

  // Zero operands are isolated so the array inputs stay quiet for skipped beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a      <= '0;
      s1_b      <= '0;
      s1_approx <= 1'b0;
      s1_zero   <= 1'b0;
    end else if (s1_load) begin
      s1_a      <= in_zero ? '0 : A;
      s1_b      <= in_zero ? '0 : B;
      s1_approx <= approx_en;
      s1_zero   <= in_zero;
    end
  end

  approx_pp_array #(
    .WIDTH      (WIDTH),
    .TRUNC_COLS (TRUNC_COLS),
    .ADDER_SEL  (ADDER_SEL)
  ) u_array (
    .a      (s1_a),
    .b      (s1_b),
    .approx (s1_approx),
    .p      (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_valid <= 1'b0;
    else if (s2_en) out_valid <= s1_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Z         <= '0;
      zero_skip <= 1'b0;
    end else if (s2_load) begin
      Z         <= s1_zero ? '0 : prod;
      zero_skip <= s1_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gated_cnt <= '0;
    else if (stat_clr) gated_cnt <= '0;
    else if (!s2_load && gated_cnt != '1) gated_cnt <= gated_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb/tb_approx_mult_pipe.sv - directed and randomized bench for approx_mult_pipe
module tb_approx_mult_pipe;
  import approx_mult_pkg::*;

  localparam int W = 16;
  localparam int K = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         approx_en = 1'b0;
  logic         out_ready = 1'b0;
  logic         stat_clr = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;

  logic           in_ready, out_valid, zero_skip;
  logic [2*W-1:0] Z;
  logic [31:0]    gated_cycles;
  logic           in_ready_c, out_valid_c, zero_skip_c;
  logic [2*W-1:0] Z_c;
  logic [31:0]    gated_cycles_c;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic        exp_zs_q[$];

  approx_mult_pipe #(.WIDTH(W), .TRUNC_COLS(K), .ADDER_SEL(ADDER_RIPPLE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .approx_en(approx_en), .out_valid(out_valid), .out_ready(out_ready), .Z(Z),
    .zero_skip(zero_skip), .stat_clr(stat_clr), .gated_cycles(gated_cycles)
  );

  approx_mult_pipe #(.WIDTH(W), .TRUNC_COLS(K), .ADDER_SEL(ADDER_CLA)) dut_cla (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c), .A(A), .B(B),
    .approx_en(approx_en), .out_valid(out_valid_c), .out_ready(out_ready), .Z(Z_c),
    .zero_skip(zero_skip_c), .stat_clr(stat_clr), .gated_cycles(gated_cycles_c)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full product minus the value of every dropped term, then the sticky compensation bit.
  function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ap);
    logic [63:0] full;
    logic [63:0] dropped;
    full = 64'(a) * 64'(b);
    if (!ap) return full;
    dropped = 0;
    for (int i = 0; i < K; i++)
      if (a[i]) dropped = dropped + ((64'(b) & ((64'(1) << (K - i)) - 1)) << i);
    full = full - dropped;
    if (dropped != 0) full = full | (64'(1) << (K - 1));
    return full;
  endfunction

  task automatic one_beat(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ap, input logic [63:0] exp_z, input logic exp_zs);
    out_ready = 1'b1;
    A = a; B = b; approx_en = ap; in_valid = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    check({tag, "_valid_early"}, out_valid, 0);
    if (exp_zs) begin
      check({tag, "_s1_a_iso"}, dut.s1_a, 0);
      check({tag, "_s1_b_iso"}, dut.s1_b, 0);
    end
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_z"}, Z, exp_z);
    check({tag, "_z_cla"}, Z_c, exp_z);
    check({tag, "_zero_skip"}, zero_skip, exp_zs);
    tick();
  endtask

  initial begin
    logic        acc;
    logic [1:0]  sel;
    logic        seen;

    // Reset state
    repeat (2) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_z", Z, 0);
    check("rst_zero_skip", zero_skip, 0);
    check("rst_gated", gated_cycles, 0);
    check("rst_s1_valid", dut.s1_valid, 0);
    rst_n = 1'b1;

    // Idle counting and clear
    repeat (10) tick();
    check("gated_idle10", gated_cycles, 10);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("gated_clr", gated_cycles, 0);
    tick();
    check("gated_after_clr", gated_cycles, 1);

    check("pkg_15x15_approx", approx_product(32'd15, 32'd15, K, 1'b1), 128);
    check("pkg_255x255_approx", approx_product(32'd255, 32'd255, K, 1'b1), 63360);

    // Directed products
    one_beat("b15a", 16'd15, 16'd15, 1'b1, 128, 1'b0);
    one_beat("b15e", 16'd15, 16'd15, 1'b0, 225, 1'b0);
    one_beat("b255a", 16'd255, 16'd255, 1'b1, 63360, 1'b0);
    one_beat("b255e", 16'd255, 16'd255, 1'b0, 65025, 1'b0);
    one_beat("bzero", 16'd0, 16'd1234, 1'b1, 0, 1'b1);

    // Backpressure: two beats fill the pipe, third is refused
    out_ready = 1'b0; approx_en = 1'b0; in_valid = 1'b1;
    A = 16'd100; B = 16'd50; #1;
    check("bp_ready1", in_ready, 1);
    tick();
    A = 16'd1000; B = 16'd200; #1;
    check("bp_ready2", in_ready, 1);
    tick();
    A = 16'd65535; B = 16'd65535; #1;
    check("bp_ready3", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_z", Z, 5000);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1; #1;
    check("bp_release_ready", in_ready, 1);
    check("bp_out1", Z, 5000);
    tick();
    in_valid = 1'b0;
    check("bp_out2", Z, 200000);
    check("bp_out2_valid", out_valid, 1);
    tick();
    check("bp_out3", Z, 64'd4294836225);
    check("bp_out3_valid", out_valid, 1);
    tick();
    check("bp_drained", out_valid, 0);

    // Randomized traffic against the reference model
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      approx_en = $urandom_range(0, 1);
      sel = 2'($urandom_range(0, 7));
      A = (sel == 0) ? '0 : (sel == 1) ? W'($urandom_range(0, 255)) : W'($urandom);
      sel = 2'($urandom_range(0, 7));
      B = (sel == 0) ? '0 : (sel == 1) ? W'($urandom_range(0, 255)) : W'($urandom);
      #1;
      if (out_valid && out_ready) begin
        check("rnd_sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("rnd_z", Z, exp_q[0]);
          check("rnd_z_cla", Z_c, exp_q[0]);
          check("rnd_zero_skip", zero_skip, exp_zs_q[0]);
          void'(exp_q.pop_front());
          void'(exp_zs_q.pop_front());
        end
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        exp_q.push_back(model(A, B, approx_en));
        exp_zs_q.push_back((A == 0) || (B == 0));
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (out_valid && exp_q.size() != 0) begin
        check("drain_z", Z, exp_q[0]);
        check("drain_zero_skip", zero_skip, exp_zs_q[0]);
        void'(exp_q.pop_front());
        void'(exp_zs_q.pop_front());
      end
      tick();
    end
    check("rnd_sb_empty", exp_q.size(), 0);

    // Saturation
    dut.gated_cnt = 32'hFFFF_FFFE;
    tick();
    check("sat_reach", gated_cycles, 32'hFFFF_FFFF);
    repeat (3) tick();
    check("sat_hold", gated_cycles, 32'hFFFF_FFFF);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("sat_clr", gated_cycles, 0);

    // Reset with two beats in flight
    out_ready = 1'b0; approx_en = 1'b0; in_valid = 1'b1;
    A = 16'd7; B = 16'd9;
    tick();
    A = 16'd11; B = 16'd13;
    tick();
    in_valid = 1'b0;
    check("mid_valid_before", out_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_z", Z, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_gated", gated_cycles, 0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("mid_no_stale", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_mult_pipe.md
# approx_mult_pipe

Parametrised, pipelined successor to the combinational 16-bit approximate multiplier. It adds valid/ready handshaking, a runtime exact/approximate mode, and truncated-column approximation with single-bit compensation. It also provides operand isolation for zero operands, register load-enable gating so idle stages hold state, and a gated-cycle counter for power accounting. It sits between operand producers and accumulators in the datapath and is the clock-gating target of the power flow.

## Interface
- WIDTH, 16, operand width; product is 2*WIDTH bits.
- TRUNC_COLS, 8, approximate mode drops partial-product columns below this index; legal range 1..WIDTH.
- ADDER_SEL, 0, final-adder implementation: 0 ripple, 1 carry-lookahead. Result is bit-identical for either value.

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- A  in  WIDTH  operand A, unsigned
- B  in  WIDTH  operand B, unsigned
- approx_en  in  1  1 = approximate, 0 = exact; sampled with the operands
- out_valid  out  1  Z valid
- out_ready  in  1  consumer accepts Z
- Z  out  2*WIDTH  product
- zero_skip  out  1  qualifies Z: the beat had A==0 or B==0
- stat_clr  in  1  synchronous clear of gated_cycles
- gated_cycles  out  32  saturating count of cycles in which the S2 register did not load

## Operation
- Two register stages.
  - S1 holds A, B, approx_en, and a zero flag.
  - S2 holds Z and zero_skip.
- Exact mode: Z = A*B.
- Approximate mode, with K = TRUNC_COLS:
  - Z = sum of a_i·b_j·2^(i+j) over all i+j ≥ K.
  - Z[K-2:0] = 0.
  - Z[K-1] = OR of all dropped terms a_i·b_j with i+j < K.
- Zero operand: if A==0 or B==0, S1 sets the zero flag and loads zeros into its operand registers (operand isolation, so the array sees no toggles). S2 produces Z = 0 and zero_skip = 1 in both modes.
- Load enables:
  - s2_en = !out_valid || out_ready
  - s1_en = !s1_valid || s2_en
  - in_ready = s1_en
- Gating: S1 data registers load only when in_valid && in_ready. S2 data registers load only when s1_valid && s2_en. Otherwise both hold their value; there is no free-running enable.
- gated_cycles:
  - Increments every cycle in which S2 does not load.
  - Saturates at 2^32-1.
  - stat_clr has priority over increment, and the cleared value is 0.

## Timing
- Reset values:
  - in_ready = 1
  - out_valid = 0
  - Z = 0
  - zero_skip = 0
  - gated_cycles = 0
  - S1 valid = 0
- Latency: a beat accepted at edge n presents out_valid at edge n+2 when there is no backpressure.
- Throughput: 1 beat/cycle.
- Backpressure: while out_valid && !out_ready, Z and zero_skip hold stable. S1 still fills if empty, so at most 2 beats are in flight. in_ready falls only when both stages are full and out_ready = 0.
- Simultaneous events:
  - out_ready and in_valid in the same cycle with both stages full: S2 drains, S1 advances, and the new beat loads. No bubble.
  - stat_clr in a cycle where S2 does not load: the result is 0, not 1.
- Reset asserted mid-operation: all in-flight beats are discarded with no output, and every output returns to its reset value immediately.
- in_ready is combinational from out_ready; there is no other combinational input-to-output path.

## Structure
- Package approx_mult_pkg holds:
  - the ADDER_SEL encodings (ADDER_RIPPLE = 0, ADDER_CLA = 1);
  - the counter width constant (32);
  - a reference function approx_product(a, b, k, approx), shared with the bench.
- Sub-module approx_pp_array (combinational) contains the partial-product generation, column truncation, compensation OR, and the final adder selected by ADDER_SEL. The top level contains only the handshake, registers, isolation, and counter.

## Test plan
All scenarios use WIDTH=16 and TRUNC_COLS=8.
- A=15, B=15: approx_en=1 gives Z=128; approx_en=0 gives Z=225. Each appears exactly 2 cycles after acceptance.
- A=255, B=255: approx_en=1 gives Z=63360; approx_en=0 gives Z=65025.
- A=0, B=1234, approx_en=1: Z=0 and zero_skip=1. S1 operand registers read 0.
- Hold out_ready=0 and offer 3 beats (100×50, 1000×200, 65535×65535, exact mode):
  - in_ready drops after 2 beats.
  - Z stays at 5000 until released.
  - After release the outputs are 5000, 200000, 4294836225 in order, with none lost.
- Hold in_valid=0 for 10 cycles after reset: gated_cycles = 10. stat_clr=1 for one cycle gives 0 the next cycle. Separately, with the count forced to 2^32-1, it stays saturated.
- Assert rst_n=0 with 2 beats in flight: out_valid=0 and Z=0 immediately, and no stale beat emerges after reset.
